// File: rtl/display_scan_mux.sv
// Registered N-to-1 display source multiplexer. In manual mode the output follows a host-selected
// source. In auto-scan mode it cycles through all sources, spending SCAN_DIV clocks on each.
// The hold input freezes the output, the index and the scan counter.
module display_scan_mux #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned NUM_IN   = 10,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned SCAN_DIV = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        select,
    input  logic                    auto_mode,
    input  logic                    hold,
    output logic [WIDTH-1:0]        mux_out,
    output logic [SEL_W-1:0]        cur_sel,
    output logic                    sel_err,
    output logic                    sel_changed
);

    // The counter keeps at least one bit so that SCAN_DIV=1 still elaborates. Its value stays 0.
    localparam int unsigned      CntW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0]  CntLast  = CntW'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] SelLast  = SEL_W'(NUM_IN - 1);
    // This value is one bit wider than select, so NUM_IN == 2**SEL_W is still representable.
    localparam logic [SEL_W:0]   NumInExt = (SEL_W + 1)'(NUM_IN);

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;
    logic             sel_err_q, sel_err_d;
    logic [WIDTH-1:0] mux_q, mux_d;
    logic             sel_changed_q, sel_changed_d;

    // Next index, scan counter and error flag. Priority: hold, then auto, then manual.
    always_comb begin
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        sel_err_d = sel_err_q;
        if (hold) begin
            // Everything stays frozen.
        end else if (auto_mode) begin
            sel_err_d = 1'b0;
            if (cnt_q == CntLast) begin
                cnt_d     = '0;
                cur_sel_d = (cur_sel_q == SelLast) ? '0 : cur_sel_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            // In manual mode the counter is held at 0.
            // Entering auto mode then gives the current index a full dwell.
            cnt_d = '0;
            if ({1'b0, select} < NumInExt) begin
                cur_sel_d = select;
                sel_err_d = 1'b0;
            end else begin
                sel_err_d = 1'b1;
            end
        end
    end

    // Data path: pick the source for the next index. Out-of-range indices cannot occur.
    always_comb begin
        mux_d = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (cur_sel_d == SEL_W'(k)) begin
                mux_d = in_bus[k*WIDTH +: WIDTH];
            end
        end
        if (hold) begin
            mux_d = mux_q;
        end
        sel_changed_d = !hold && (cur_sel_d != cur_sel_q);
    end

    // State registers with synchronous active-low reset, which overrides hold and mode.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q         <= '0;
            cur_sel_q     <= '0;
            sel_err_q     <= 1'b0;
            mux_q         <= '0;
            sel_changed_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            cur_sel_q     <= cur_sel_d;
            sel_err_q     <= sel_err_d;
            mux_q         <= mux_d;
            sel_changed_q <= sel_changed_d;
        end
    end

    assign mux_out     = mux_q;
    assign cur_sel     = cur_sel_q;
    assign sel_err     = sel_err_q;
    assign sel_changed = sel_changed_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux.
// The main instance uses SCAN_DIV=4. It is checked every cycle against a scoreboard of expected
// outputs, plus fixed-value checks for the key scenarios. A second, small instance
// (WIDTH=8, NUM_IN=3, SEL_W=2, SCAN_DIV=1) covers the parameter corners.
module tb_display_scan_mux;

    logic         clock;
    logic         reset_n;
    logic [159:0] bus;
    logic [3:0]   select;
    logic         auto_mode;
    logic         hold;
    logic [15:0]  mux_out;
    logic [3:0]   cur_sel;
    logic         sel_err;
    logic         sel_changed;

    logic         rst2;
    logic [23:0]  bus2;
    logic [1:0]   sel2;
    logic         auto2;
    logic         hold2;
    logic [7:0]   mux2;
    logic [1:0]   cs2;
    logic         err2;
    logic         chg2;

    int n_checks = 0;
    int n_fail   = 0;

    display_scan_mux #(
        .WIDTH   (16),
        .NUM_IN  (10),
        .SEL_W   (4),
        .SCAN_DIV(4)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_bus     (bus),
        .select     (select),
        .auto_mode  (auto_mode),
        .hold       (hold),
        .mux_out    (mux_out),
        .cur_sel    (cur_sel),
        .sel_err    (sel_err),
        .sel_changed(sel_changed)
    );

    display_scan_mux #(
        .WIDTH   (8),
        .NUM_IN  (3),
        .SEL_W   (2),
        .SCAN_DIV(1)
    ) u_dut_small (
        .clock      (clock),
        .reset_n    (rst2),
        .in_bus     (bus2),
        .select     (sel2),
        .auto_mode  (auto2),
        .hold       (hold2),
        .mux_out    (mux2),
        .cur_sel    (cs2),
        .sel_err    (err2),
        .sel_changed(chg2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] mux;
        logic [3:0]  sel;
        logic        err;
        logic        chg;
    } exp_t;

    exp_t sb[$];

    // Behavioural model state for the main instance.
    logic [15:0] m_mux;
    logic [3:0]  m_sel;
    logic        m_err;
    logic        m_chg;
    int          m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] s, input logic a, input logic h);
        logic [3:0] nxt;
        exp_t       e;
        if (!r) begin
            m_sel = '0; m_cnt = 0; m_err = 1'b0; m_mux = '0; m_chg = 1'b0;
        end else if (h) begin
            m_chg = 1'b0;
        end else begin
            nxt = m_sel;
            if (!a) begin
                m_cnt = 0;
                if (s < 4'd10) begin
                    nxt   = s;
                    m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end else begin
                m_err = 1'b0;
                if (m_cnt == 3) begin
                    m_cnt = 0;
                    nxt   = (m_sel == 4'd9) ? 4'd0 : m_sel + 4'd1;
                end else begin
                    m_cnt++;
                end
            end
            m_chg = (nxt != m_sel);
            m_sel = nxt;
            m_mux = bus[nxt*16 +: 16];
        end
        e.mux = m_mux; e.sel = m_sel; e.err = m_err; e.chg = m_chg;
        sb.push_back(e);
    endtask

    // Drive one cycle on the main instance and compare against the scoreboard head.
    task automatic cycle(input logic r, input logic [3:0] s, input logic a, input logic h);
        exp_t e;
        reset_n   = r;
        select    = s;
        auto_mode = a;
        hold      = h;
        model_step(r, s, a, h);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check("mux_out", {16'd0, mux_out}, {16'd0, e.mux});
        check("cur_sel", {28'd0, cur_sel}, {28'd0, e.sel});
        check("sel_err", {31'd0, sel_err}, {31'd0, e.err});
        check("sel_changed", {31'd0, sel_changed}, {31'd0, e.chg});
    endtask

    task automatic restore_bus();
        for (int k = 0; k < 10; k++) bus[k*16 +: 16] = 16'h1111 * 16'(k);
    endtask

    initial begin
        logic [3:0] seq [8];
        logic       found;
        seq = '{4'd8, 4'd8, 4'd8, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0};
        restore_bus();
        rst2  = 1'b0; sel2 = '0; auto2 = 1'b0; hold2 = 1'b0;
        bus2  = {8'hC2, 8'hB1, 8'hA0};

        // Reset wins over hold and auto mode.
        cycle(1'b0, 4'd7, 1'b1, 1'b1);
        cycle(1'b0, 4'd7, 1'b1, 1'b1);
        check("rst_cur_sel", {28'd0, cur_sel}, 32'd0);
        check("rst_mux", {16'd0, mux_out}, 32'd0);

        // Manual sweep over every source.
        for (int s = 0; s < 10; s++) begin
            cycle(1'b1, 4'(s), 1'b0, 1'b0);
            check("sweep_mux", {16'd0, mux_out}, 32'h1111 * s);
            check("sweep_err", {31'd0, sel_err}, 32'd0);
        end

        // An out-of-range select keeps the index and keeps tracking that source.
        cycle(1'b1, 4'd3, 1'b0, 1'b0);
        cycle(1'b1, 4'd12, 1'b0, 1'b0);
        check("oor_cur_sel", {28'd0, cur_sel}, 32'd3);
        check("oor_mux", {16'd0, mux_out}, 32'h3333);
        check("oor_err", {31'd0, sel_err}, 32'd1);
        bus[3*16 +: 16] = 16'hABCD;
        cycle(1'b1, 4'd15, 1'b0, 1'b0);
        check("oor_track", {16'd0, mux_out}, 32'hABCD);
        restore_bus();
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        check("oor_clear_err", {31'd0, sel_err}, 32'd0);
        check("oor_clear_mux", {16'd0, mux_out}, 32'h5555);
        cycle(1'b1, 4'd5, 1'b0, 1'b0);
        check("reload_no_chg", {31'd0, sel_changed}, 32'd0);

        // Auto scan starting from index 8, then wrapping to 0.
        cycle(1'b1, 4'd8, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'd2, 1'b1, 1'b0);
            check("scan_seq", {28'd0, cur_sel}, {28'd0, seq[i]});
        end

        // Advance to index 4 with the counter at 2, then hold for 10 cycles.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (m_sel == 4'd4 && m_cnt == 2) found = 1'b1;
            else cycle(1'b1, 4'd0, 1'b1, 1'b0);
        end
        check("hold_seek", {31'd0, found}, 32'd1);
        bus[4*16 +: 16] = 16'hDEAD;
        bus[5*16 +: 16] = 16'hBEEF;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 4'($urandom_range(15)), 1'($urandom_range(1)), 1'b1);
        end
        check("hold_mux", {16'd0, mux_out}, 32'h4444);
        check("hold_sel", {28'd0, cur_sel}, 32'd4);
        restore_bus();
        cycle(1'b1, 4'd0, 1'b1, 1'b0);
        check("release_1", {28'd0, cur_sel}, 32'd4);
        cycle(1'b1, 4'd0, 1'b1, 1'b0);
        check("release_2", {28'd0, cur_sel}, 32'd5);
        check("release_mux", {16'd0, mux_out}, 32'h5555);

        // Reset during a scan with hold asserted; scanning then restarts at index 0.
        cycle(1'b1, 4'd0, 1'b1, 1'b0);
        cycle(1'b0, 4'd9, 1'b1, 1'b1);
        check("midrst_mux", {16'd0, mux_out}, 32'd0);
        check("midrst_sel", {28'd0, cur_sel}, 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 4'd9, 1'b1, 1'b0);
        check("restart_dwell", {28'd0, cur_sel}, 32'd0);
        cycle(1'b1, 4'd9, 1'b1, 1'b0);
        check("restart_adv", {28'd0, cur_sel}, 32'd1);

        // Leaving auto mode applies select on the first manual edge.
        cycle(1'b1, 4'd7, 1'b0, 1'b0);
        check("auto2man", {28'd0, cur_sel}, 32'd7);

        // Random traffic, checked against the model.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) begin
                bus[$urandom_range(9)*16 +: 16] = 16'($urandom);
            end
            cycle(1'($urandom_range(19) != 0), 4'($urandom_range(15)),
                  1'($urandom_range(1)), 1'($urandom_range(4) == 0));
        end

        // Small instance: SCAN_DIV=1 advances every clock.
        rst2 = 1'b0;
        @(posedge clock); #1;
        check("p2_rst_sel", {30'd0, cs2}, 32'd0);
        rst2  = 1'b1;
        auto2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            check("p2_scan_sel", {30'd0, cs2}, (i + 1) % 3);
            check("p2_scan_mux", {24'd0, mux2}, 32'hA0 + 32'h11 * ((i + 1) % 3));
            check("p2_scan_chg", {31'd0, chg2}, 32'd1);
        end
        auto2 = 1'b0;
        sel2  = 2'd3;
        @(posedge clock); #1;
        check("p2_oor_err", {31'd0, err2}, 32'd1);
        check("p2_oor_sel", {30'd0, cs2}, 32'd1);
        sel2 = 2'd2;
        @(posedge clock); #1;
        check("p2_sel_err", {31'd0, err2}, 32'd0);
        check("p2_sel_mux", {24'd0, mux2}, 32'hC2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
